// File: rtl/ct_mmu_sysmap_arb.sv
// Three-way round-robin arbiter in front of the shared sysmap lookup.
// The granted lookup result is registered with a 1-cycle latency and a valid/ready handshake.
module ct_mmu_sysmap_arb #(
    parameter int PA_W  = 28,
    parameter int FLG_W = 5
) (
    input  logic             cpuclk,
    input  logic             cpurst_b,
    input  logic             req0_vld,
    input  logic [PA_W-1:0]  req0_pa,
    output logic             req0_rdy,
    input  logic             req1_vld,
    input  logic [PA_W-1:0]  req1_pa,
    output logic             req1_rdy,
    input  logic             req2_vld,
    input  logic [PA_W-1:0]  req2_pa,
    output logic             req2_rdy,
    output logic [PA_W-1:0]  arb_sysmap_pa,
    input  logic [FLG_W-1:0] sysmap_arb_flg,
    input  logic [7:0]       sysmap_arb_hit,
    output logic             rslt_vld,
    output logic [1:0]       rslt_id,
    output logic [FLG_W-1:0] rslt_flg,
    output logic             rslt_miss,
    input  logic             rslt_rdy,
    input  logic             flush
);

    logic [1:0] ptr;
    logic [1:0] sel;
    logic       any_vld;
    logic       can_grant;
    logic       grant;

    // Walk the requesters in priority order from ptr; sel falls back to ptr when none is valid.
    always_comb begin
        sel     = ptr;
        any_vld = 1'b1;
        case (ptr)
            2'd1: begin
                if (req1_vld)      sel = 2'd1;
                else if (req2_vld) sel = 2'd2;
                else if (req0_vld) sel = 2'd0;
                else               any_vld = 1'b0;
            end
            2'd2: begin
                if (req2_vld)      sel = 2'd2;
                else if (req0_vld) sel = 2'd0;
                else if (req1_vld) sel = 2'd1;
                else               any_vld = 1'b0;
            end
            default: begin
                if (req0_vld)      sel = 2'd0;
                else if (req1_vld) sel = 2'd1;
                else if (req2_vld) sel = 2'd2;
                else               any_vld = 1'b0;
            end
        endcase
    end

    assign can_grant = !flush && (!rslt_vld || rslt_rdy);
    assign grant     = can_grant && any_vld;

    assign req0_rdy = grant && (sel == 2'd0);
    assign req1_rdy = grant && (sel == 2'd1);
    assign req2_rdy = grant && (sel == 2'd2);

    always_comb begin
        case (sel)
            2'd1:    arb_sysmap_pa = req1_pa;
            2'd2:    arb_sysmap_pa = req2_pa;
            default: arb_sysmap_pa = req0_pa;
        endcase
    end

    // Flush wins over both a new grant and a consumer accept; ptr only moves on a grant.
    always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ptr       <= 2'd0;
            rslt_vld  <= 1'b0;
            rslt_id   <= 2'd0;
            rslt_flg  <= '0;
            rslt_miss <= 1'b0;
        end else if (flush) begin
            rslt_vld <= 1'b0;
        end else if (grant) begin
            rslt_vld  <= 1'b1;
            rslt_id   <= sel;
            rslt_flg  <= sysmap_arb_flg;
            rslt_miss <= ~|sysmap_arb_hit;
            ptr       <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
        end else if (rslt_rdy) begin
            rslt_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ct_mmu_sysmap_arb.sv
// Directed table-driven bench for ct_mmu_sysmap_arb plus an async-reset sequence.
module tb_ct_mmu_sysmap_arb;

    localparam int PA_W  = 28;
    localparam int FLG_W = 5;

    logic             cpuclk;
    logic             cpurst_b;
    logic             req0_vld, req1_vld, req2_vld;
    logic [PA_W-1:0]  req0_pa, req1_pa, req2_pa;
    logic             req0_rdy, req1_rdy, req2_rdy;
    logic [PA_W-1:0]  arb_sysmap_pa;
    logic [FLG_W-1:0] sysmap_arb_flg;
    logic [7:0]       sysmap_arb_hit;
    logic             rslt_vld;
    logic [1:0]       rslt_id;
    logic [FLG_W-1:0] rslt_flg;
    logic             rslt_miss;
    logic             rslt_rdy;
    logic             flush;

    int errors = 0;
    int checks = 0;

    ct_mmu_sysmap_arb #(.PA_W(PA_W), .FLG_W(FLG_W)) dut (
        .cpuclk(cpuclk), .cpurst_b(cpurst_b),
        .req0_vld(req0_vld), .req0_pa(req0_pa), .req0_rdy(req0_rdy),
        .req1_vld(req1_vld), .req1_pa(req1_pa), .req1_rdy(req1_rdy),
        .req2_vld(req2_vld), .req2_pa(req2_pa), .req2_rdy(req2_rdy),
        .arb_sysmap_pa(arb_sysmap_pa),
        .sysmap_arb_flg(sysmap_arb_flg), .sysmap_arb_hit(sysmap_arb_hit),
        .rslt_vld(rslt_vld), .rslt_id(rslt_id), .rslt_flg(rslt_flg),
        .rslt_miss(rslt_miss), .rslt_rdy(rslt_rdy), .flush(flush)
    );

    initial begin
        cpuclk = 1'b0;
        forever #5 cpuclk = ~cpuclk;
    end

    typedef struct {
        logic [2:0] vld;
        logic       rr;
        logic       fl;
        logic [7:0] hit;
        logic [4:0] flg;
        logic [2:0] exp_rdy;
        logic [1:0] exp_pa;
        logic       exp_vld;
        logic [1:0] exp_id;
        logic [4:0] exp_flg;
        logic       exp_miss;
    } vec_t;

    localparam int NV = 17;
    vec_t vt[NV];
    logic [PA_W-1:0] pa_tab[3];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    initial begin
        pa_tab[0] = 28'h0001000;
        pa_tab[1] = 28'h0002000;
        pa_tab[2] = 28'h0003000;

        //          vld     rr    fl    hit    flg       rdy     pa    vld   id     flg      miss
        vt[0]  = '{3'b111, 1'b1, 1'b0, 8'h01, 5'b01111, 3'b001, 2'd0, 1'b1, 2'd0, 5'b01111, 1'b0};
        vt[1]  = '{3'b111, 1'b1, 1'b0, 8'h80, 5'b00001, 3'b010, 2'd1, 1'b1, 2'd1, 5'b00001, 1'b0};
        vt[2]  = '{3'b111, 1'b1, 1'b0, 8'h00, 5'b00010, 3'b100, 2'd2, 1'b1, 2'd2, 5'b00010, 1'b1};
        vt[3]  = '{3'b111, 1'b1, 1'b0, 8'h00, 5'b10011, 3'b001, 2'd0, 1'b1, 2'd0, 5'b10011, 1'b1};
        vt[4]  = '{3'b111, 1'b1, 1'b0, 8'h04, 5'b00100, 3'b010, 2'd1, 1'b1, 2'd1, 5'b00100, 1'b0};
        vt[5]  = '{3'b111, 1'b1, 1'b0, 8'h02, 5'b01000, 3'b100, 2'd2, 1'b1, 2'd2, 5'b01000, 1'b0};
        vt[6]  = '{3'b000, 1'b1, 1'b0, 8'h01, 5'b00000, 3'b000, 2'd0, 1'b0, 2'd0, 5'b00000, 1'b0};
        vt[7]  = '{3'b001, 1'b0, 1'b0, 8'h01, 5'b01111, 3'b001, 2'd0, 1'b1, 2'd0, 5'b01111, 1'b0};
        vt[8]  = '{3'b010, 1'b0, 1'b0, 8'h00, 5'b11111, 3'b000, 2'd1, 1'b1, 2'd0, 5'b01111, 1'b0};
        vt[9]  = '{3'b010, 1'b0, 1'b0, 8'h00, 5'b11111, 3'b000, 2'd1, 1'b1, 2'd0, 5'b01111, 1'b0};
        vt[10] = '{3'b010, 1'b0, 1'b0, 8'h00, 5'b11111, 3'b000, 2'd1, 1'b1, 2'd0, 5'b01111, 1'b0};
        vt[11] = '{3'b010, 1'b1, 1'b0, 8'h00, 5'b10011, 3'b010, 2'd1, 1'b1, 2'd1, 5'b10011, 1'b1};
        vt[12] = '{3'b000, 1'b0, 1'b0, 8'h01, 5'b00000, 3'b000, 2'd2, 1'b1, 2'd1, 5'b10011, 1'b1};
        vt[13] = '{3'b100, 1'b1, 1'b1, 8'h01, 5'b00101, 3'b000, 2'd2, 1'b0, 2'd0, 5'b00000, 1'b0};
        vt[14] = '{3'b101, 1'b0, 1'b0, 8'h10, 5'b00111, 3'b100, 2'd2, 1'b1, 2'd2, 5'b00111, 1'b0};
        vt[15] = '{3'b011, 1'b0, 1'b1, 8'h01, 5'b00001, 3'b000, 2'd0, 1'b0, 2'd0, 5'b00000, 1'b0};
        vt[16] = '{3'b000, 1'b0, 1'b0, 8'h01, 5'b00001, 3'b000, 2'd0, 1'b0, 2'd0, 5'b00000, 1'b0};

        cpurst_b = 1'b0;
        {req2_vld, req1_vld, req0_vld} = 3'b000;
        req0_pa = pa_tab[0];
        req1_pa = pa_tab[1];
        req2_pa = pa_tab[2];
        sysmap_arb_flg = '0;
        sysmap_arb_hit = '0;
        rslt_rdy = 1'b0;
        flush = 1'b0;

        #2;
        chk("reset_vld", -1, 32'(rslt_vld), 32'd0);
        chk("reset_id", -1, 32'(rslt_id), 32'd0);
        chk("reset_flg", -1, 32'(rslt_flg), 32'd0);
        chk("reset_miss", -1, 32'(rslt_miss), 32'd0);
        #10 cpurst_b = 1'b1;
        @(posedge cpuclk); #1;

        for (int i = 0; i < NV; i++) begin
            {req2_vld, req1_vld, req0_vld} = vt[i].vld;
            rslt_rdy       = vt[i].rr;
            flush          = vt[i].fl;
            sysmap_arb_hit = vt[i].hit;
            sysmap_arb_flg = vt[i].flg;
            #1;
            chk("rdy", i, 32'({req2_rdy, req1_rdy, req0_rdy}), 32'(vt[i].exp_rdy));
            chk("pa", i, 32'(arb_sysmap_pa), 32'(pa_tab[vt[i].exp_pa]));
            @(posedge cpuclk); #1;
            chk("rslt_vld", i, 32'(rslt_vld), 32'(vt[i].exp_vld));
            if (vt[i].exp_vld) begin
                chk("rslt_id", i, 32'(rslt_id), 32'(vt[i].exp_id));
                chk("rslt_flg", i, 32'(rslt_flg), 32'(vt[i].exp_flg));
                chk("rslt_miss", i, 32'(rslt_miss), 32'(vt[i].exp_miss));
            end
        end

        // Async reset mid-cycle with a result pending: ptr is 0 here, so req1 is granted.
        {req2_vld, req1_vld, req0_vld} = 3'b010;
        sysmap_arb_flg = 5'b11011;
        sysmap_arb_hit = 8'h00;
        rslt_rdy = 1'b0;
        @(posedge cpuclk); #1;
        chk("ar_pre_vld", 100, 32'(rslt_vld), 32'd1);
        chk("ar_pre_id", 100, 32'(rslt_id), 32'd1);
        {req2_vld, req1_vld, req0_vld} = 3'b000;
        #2 cpurst_b = 1'b0;
        #1;
        chk("ar_vld", 101, 32'(rslt_vld), 32'd0);
        chk("ar_id", 101, 32'(rslt_id), 32'd0);
        chk("ar_flg", 101, 32'(rslt_flg), 32'd0);
        chk("ar_miss", 101, 32'(rslt_miss), 32'd0);
        #2 cpurst_b = 1'b1;
        {req2_vld, req1_vld, req0_vld} = 3'b110;
        sysmap_arb_hit = 8'h08;
        rslt_rdy = 1'b1;
        #1;
        chk("ar_post_rdy", 102, 32'({req2_rdy, req1_rdy, req0_rdy}), 32'b010);
        @(posedge cpuclk); #1;
        chk("ar_post_vld", 102, 32'(rslt_vld), 32'd1);
        chk("ar_post_id", 102, 32'(rslt_id), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ct_mmu_sysmap_arb.md
CT_MMU_SYSMAP_ARB -- requirements
Module: ct_mmu_sysmap_arb

Interface
REQ-001 SHALL have parameter PA_W, default 28, meaning physical page number width (PA_WIDTH-12).
REQ-002 SHALL have parameter FLG_W, default 5, meaning sysmap attribute flag width.
REQ-003 SHALL have cpuclk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have cpurst_b  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have reqN_vld  input  1  (N=0,1,2) lookup request valid from requester N.
REQ-006 SHALL have reqN_pa  input  PA_W  (N=0,1,2) page number to look up.
REQ-007 SHALL have reqN_rdy  output  1  (N=0,1,2) grant; the request is accepted in a cycle where reqN_vld and reqN_rdy are both high.
REQ-008 SHALL have arb_sysmap_pa  output  PA_W  page number driven to the shared sysmap lookup.
REQ-009 SHALL have sysmap_arb_flg  input  FLG_W  combinational flag returned by the sysmap.
REQ-010 SHALL have sysmap_arb_hit  input  8  combinational one-hot region hit vector.
REQ-011 SHALL have rslt_vld  output  1  result valid.
REQ-012 SHALL have rslt_id  output  2  index of the requester that owns the result.
REQ-013 SHALL have rslt_flg  output  FLG_W  registered flag.
REQ-014 SHALL have rslt_miss  output  1  no region hit (sysmap_arb_hit == 0).
REQ-015 SHALL have rslt_rdy  input  1  consumer accepts the result.
REQ-016 SHALL have flush  input  1  cancels the pending result and blocks grants.

Function
REQ-017 SHALL compute can_grant = !flush && (!rslt_vld || rslt_rdy).
REQ-018 SHALL assert at most one reqN_rdy per cycle; reqN_rdy = can_grant && reqN_vld && N is the first valid requester in round-robin order starting at ptr.
REQ-019 SHALL drive reqN_rdy combinationally from reqN_vld, ptr, rslt_vld, rslt_rdy and flush, with no dependence on reqN_pa.
REQ-020 SHALL hold a 2-bit round-robin pointer ptr in the range 0..2; on a grant to N, ptr becomes (N+1) mod 3; ptr holds when no grant occurs; ptr SHALL never equal 3.
REQ-021 SHALL drive arb_sysmap_pa = pa of the selected requester, or the pa of requester ptr when there is no valid requester.
REQ-022 SHALL make a grant in cycle T set rslt_vld=1 in cycle T+1, with rslt_id=N, rslt_flg=sysmap_arb_flg, and rslt_miss=~|sysmap_arb_hit, all sampled in cycle T (1-cycle latency).
REQ-023 SHALL clear rslt_vld when rslt_vld && rslt_rdy && no new grant occurs.
REQ-024 SHALL support back-to-back operation: when rslt_rdy and a new grant occur in the same cycle, the result register is reloaded and rslt_vld stays 1, giving 1 lookup/cycle.
REQ-025 SHALL hold rslt_id, rslt_flg and rslt_miss stable while rslt_vld && !rslt_rdy.
REQ-026 SHALL, on flush, clear rslt_vld on the next edge regardless of rslt_rdy, deassert all reqN_rdy that cycle, and leave ptr unchanged.
REQ-027 SHALL give flush priority when flush coincides with an accept (rslt_rdy) or with pending requests: nothing is granted or loaded.
REQ-028 SHALL treat a requester whose reqN_vld deasserts before grant as withdrawn, with no state effect.
REQ-029 SHALL leave rslt_flg and rslt_miss don't-care when rslt_vld=0; they are updated only on grant.

Reset
REQ-030 SHALL, while cpurst_b=0 and independent of cpuclk, set rslt_vld=0, rslt_id=0, rslt_flg=0, rslt_miss=0 and ptr=0.
REQ-031 SHALL drop any in-flight result on reset assertion mid-operation; after release, the first grant goes to the lowest-index valid requester.

Verification
REQ-032 SHALL pass this case: reset; req0_vld=1 with req0_pa=0x0001000, sysmap_arb_flg=5'b01111, sysmap_arb_hit=8'h01 -> req0_rdy=1 in T, and in T+1 rslt_vld=1, rslt_id=0, rslt_flg=01111, rslt_miss=0.
REQ-033 SHALL pass this case: all three reqN_vld held high, rslt_rdy=1 -> grants 0,1,2,0,1,2 on consecutive cycles, rslt_vld continuously 1 from T+1.
REQ-034 SHALL pass this case: rslt_vld=1, rslt_rdy=0, req1_vld=1 for 3 cycles -> req1_rdy=0 and rslt_* stable; rslt_rdy=1 in the 4th cycle -> req1_rdy=1 that cycle and rslt_id=1 next cycle.
REQ-035 SHALL pass this case: sysmap_arb_hit=8'h00, sysmap_arb_flg=5'b10011 on a grant -> rslt_miss=1, rslt_flg=10011.
REQ-036 SHALL pass this case: flush=1 with rslt_vld=1, rslt_rdy=1 and req2_vld=1 -> no reqN_rdy, rslt_vld=0 next cycle, ptr unchanged; flush=0 next cycle -> req2 granted.
REQ-037 SHALL pass this case: cpurst_b asserted asynchronously mid-cycle with rslt_vld=1 -> rslt_vld=0 immediately, before the next clock edge.
